// File: rtl/microwave_timer_ctrl.sv
// rtl/microwave_timer_ctrl.sv - BCD cook timer, power duty cycle, door interlock and alert FSM
module microwave_timer_ctrl #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int MIN_DIGITS    = 1,
    parameter int DUTY_WINDOW_S = 10,
    parameter int DONE_SECS     = 3
) (
    input  logic                    clk,
    input  logic                    clearn,
    input  logic [9:0]              keypad,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    powern,
    input  logic                    door_closed,
    output logic [6:0]              seconds_ones_out,
    output logic [6:0]              seconds_tens_out,
    output logic [7*MIN_DIGITS-1:0] minutes_out,
    output logic [3:0]              power_level,
    output logic                    mag_on,
    output logic                    done
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int CW = $clog2(DONE_SECS + 1);
    localparam int MW = 4 * MIN_DIGITS;

    localparam logic [3:0]    FULL_POWER = 4'(DUTY_WINDOW_S);
    localparam logic [3:0]    DUTY_LAST  = 4'(DUTY_WINDOW_S - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] DONE_LAST  = CW'(DONE_SECS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PWR_SET = 3'd1,
        S_COOK    = 3'd2,
        S_PAUSED  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_startn_q;
    logic            r_stopn_q;
    logic            r_powern_q;
    logic [9:0]      r_keypad_q;
    logic [3:0]      r_ones;
    logic [3:0]      r_tens;
    logic [MW-1:0]   r_min;
    logic [3:0]      r_power;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_duty;
    logic [CW-1:0]   r_done_cnt;
    logic            r_done;

    logic            w_start_ev;
    logic            w_stop_ev;
    logic            w_power_ev;
    logic            w_key_onehot;
    logic            w_key_ev;
    logic [3:0]      w_key_val;
    logic [3:0]      w_key_power;
    logic            w_tick;
    logic            w_time_zero;
    logic [3:0]      w_dec_ones;
    logic [3:0]      w_dec_tens;
    logic [MW-1:0]   w_dec_min;
    logic            w_dec_zero;
    logic [MW-1:0]   w_min_shift;
    logic            w_mag_req;

    // Standard common-cathode style 0-9 patterns, bit0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Buttons are active-low: an event is a 1 -> 0 transition seen against last cycle.
    assign w_start_ev = r_startn_q & ~startn;
    assign w_stop_ev  = r_stopn_q  & ~stopn;
    assign w_power_ev = r_powern_q & ~powern;

    // A key counts only when the pad was idle last cycle and exactly one key is down now.
    assign w_key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign w_key_ev     = w_key_onehot && (r_keypad_q == 10'd0);

    // Encode the pressed key to its digit value.
    always_comb begin
        w_key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                w_key_val = 4'(i);
            end
        end
    end

    // Key 0 or anything past the window means full power.
    assign w_key_power = ((w_key_val == 4'd0) || (w_key_val >= FULL_POWER)) ? FULL_POWER : w_key_val;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_time_zero = (r_ones == 4'd0) && (r_tens == 4'd0) && (r_min == '0);

    // One-second BCD decrement; a tens borrow always reloads 5 so entered 6..9 tens count down as-is.
    always_comb begin
        logic borrow;
        borrow     = 1'b0;
        w_dec_ones = r_ones;
        w_dec_tens = r_tens;
        w_dec_min  = r_min;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else begin
            w_dec_ones = 4'd9;
            if (r_tens != 4'd0) begin
                w_dec_tens = r_tens - 4'd1;
            end else begin
                w_dec_tens = 4'd5;
                borrow     = 1'b1;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (r_min[i*4 +: 4] != 4'd0) begin
                    w_dec_min[i*4 +: 4] = r_min[i*4 +: 4] - 4'd1;
                    borrow              = 1'b0;
                end else begin
                    w_dec_min[i*4 +: 4] = 4'd9;
                end
            end
        end
    end

    assign w_dec_zero = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_min == '0);

    // Keypad entry shifts left: tens moves into minute digit 0, the top minute digit falls off.
    always_comb begin
        w_min_shift       = '0;
        w_min_shift[3:0]  = r_tens;
        for (int i = 1; i < MIN_DIGITS; i++) begin
            w_min_shift[i*4 +: 4] = r_min[(i-1)*4 +: 4];
        end
    end

    // Main controller: input edge history, digits, power, prescaler, duty and alert counters.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_state    <= S_IDLE;
            r_startn_q <= 1'b1;
            r_stopn_q  <= 1'b1;
            r_powern_q <= 1'b1;
            r_keypad_q <= 10'd0;
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_min      <= '0;
            r_power    <= FULL_POWER;
            r_presc    <= '0;
            r_duty     <= 4'd0;
            r_done_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_startn_q <= startn;
            r_stopn_q  <= stopn;
            r_powern_q <= powern;
            r_keypad_q <= keypad;

            case (r_state)
                S_IDLE: begin
                    if (w_stop_ev) begin
                        r_ones  <= 4'd0;
                        r_tens  <= 4'd0;
                        r_min   <= '0;
                        r_power <= FULL_POWER;
                    end else if (w_start_ev) begin
                        if (door_closed && !w_time_zero) begin
                            r_state <= S_COOK;
                            r_presc <= '0;
                            r_duty  <= 4'd0;
                        end
                    end else if (w_key_ev) begin
                        r_ones <= w_key_val;
                        r_tens <= r_ones;
                        r_min  <= w_min_shift;
                    end else if (w_power_ev) begin
                        r_state <= S_PWR_SET;
                    end
                end

                S_PWR_SET: begin
                    if (w_stop_ev) begin
                        r_state <= S_IDLE;
                    end else if (w_key_ev) begin
                        r_power <= w_key_power;
                        r_state <= S_IDLE;
                    end
                end

                S_COOK: begin
                    if (!door_closed || w_stop_ev) begin
                        r_state <= S_PAUSED;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        r_ones  <= w_dec_ones;
                        r_tens  <= w_dec_tens;
                        r_min   <= w_dec_min;
                        r_duty  <= (r_duty == DUTY_LAST) ? 4'd0 : r_duty + 4'd1;
                        if (w_dec_zero) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_done_cnt <= '0;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                S_PAUSED: begin
                    if (w_stop_ev) begin
                        r_state <= S_IDLE;
                        r_ones  <= 4'd0;
                        r_tens  <= 4'd0;
                        r_min   <= '0;
                    end else if (w_start_ev && door_closed) begin
                        r_state <= S_COOK;
                        r_presc <= '0;
                    end
                end

                S_DONE: begin
                    if (w_stop_ev || w_start_ev || !door_closed) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_done_cnt == DONE_LAST) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end else begin
                            r_done_cnt <= r_done_cnt + 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Magnetron request comes from registers only; the door gate stays combinational for safety.
    assign w_mag_req   = (r_state == S_COOK) && (r_duty < r_power);
    assign mag_on      = w_mag_req & door_closed;
    assign done        = r_done;
    assign power_level = r_power;

    // Seven-segment decode of the held digits.
    always_comb begin
        seconds_ones_out = seg7(r_ones);
        seconds_tens_out = seg7(r_tens);
        minutes_out      = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            minutes_out[i*7 +: 7] = seg7(r_min[i*4 +: 4]);
        end
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb/tb_microwave_timer_ctrl.sv - directed and randomized checks against a seconds-level model
module tb_microwave_timer_ctrl;

    localparam int TPS = 4;
    localparam int MDG = 1;
    localparam int DWS = 10;
    localparam int DSS = 3;

    localparam int M_IDLE   = 0;
    localparam int M_PWR    = 1;
    localparam int M_COOK   = 2;
    localparam int M_PAUSED = 3;
    localparam int M_DONE   = 4;

    logic           clk;
    logic           clearn;
    logic [9:0]     keypad;
    logic           startn;
    logic           stopn;
    logic           powern;
    logic           door_closed;
    logic [6:0]     seconds_ones_out;
    logic [6:0]     seconds_tens_out;
    logic [7*MDG-1:0] minutes_out;
    logic [3:0]     power_level;
    logic           mag_on;
    logic           done;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: time as minutes and a 0..99 seconds field.
    int         m_state;
    int         m_min;
    int         m_sec;
    int         m_power;
    int         m_presc;
    int         m_duty;
    int         m_dcnt;
    logic       m_pstart;
    logic       m_pstop;
    logic       m_ppower;
    logic [9:0] m_pkey;

    microwave_timer_ctrl #(
        .TICKS_PER_SEC (TPS),
        .MIN_DIGITS    (MDG),
        .DUTY_WINDOW_S (DWS),
        .DONE_SECS     (DSS)
    ) dut (
        .clk              (clk),
        .clearn           (clearn),
        .keypad           (keypad),
        .startn           (startn),
        .stopn            (stopn),
        .powern           (powern),
        .door_closed      (door_closed),
        .seconds_ones_out (seconds_ones_out),
        .seconds_tens_out (seconds_tens_out),
        .minutes_out      (minutes_out),
        .power_level      (power_level),
        .mag_on           (mag_on),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs present now.
    task automatic model_edge();
        logic st, sp, pw, ke;
        int   k, n, lim;
        if (!clearn) begin
            m_state = M_IDLE; m_min = 0; m_sec = 0; m_power = DWS;
            m_presc = 0; m_duty = 0; m_dcnt = 0;
            m_pstart = 1'b1; m_pstop = 1'b1; m_ppower = 1'b1; m_pkey = '0;
            return;
        end
        st = m_pstart && !startn;
        sp = m_pstop && !stopn;
        pw = m_ppower && !powern;
        ke = (m_pkey == 10'd0) && ($countones(keypad) == 1);
        k = 0;
        for (int i = 0; i < 10; i++) if (keypad[i]) k = i;
        m_pstart = startn; m_pstop = stopn; m_ppower = powern; m_pkey = keypad;
        lim = 100;
        for (int i = 0; i < MDG; i++) lim = lim * 10;
        case (m_state)
            M_IDLE: begin
                if (sp) begin
                    m_min = 0; m_sec = 0; m_power = DWS;
                end else if (st) begin
                    if (door_closed && (m_min != 0 || m_sec != 0)) begin
                        m_state = M_COOK; m_presc = 0; m_duty = 0;
                    end
                end else if (ke) begin
                    n = ((m_min * 100 + m_sec) * 10 + k) % lim;
                    m_min = n / 100; m_sec = n % 100;
                end else if (pw) begin
                    m_state = M_PWR;
                end
            end
            M_PWR: begin
                if (sp) m_state = M_IDLE;
                else if (ke) begin
                    m_power = (k == 0 || k >= DWS) ? DWS : k;
                    m_state = M_IDLE;
                end
            end
            M_COOK: begin
                if (!door_closed || sp) m_state = M_PAUSED;
                else begin
                    m_presc++;
                    if (m_presc == TPS) begin
                        m_presc = 0;
                        if (m_sec > 0) m_sec--;
                        else begin m_sec = 59; m_min--; end
                        m_duty = (m_duty + 1) % DWS;
                        if (m_min == 0 && m_sec == 0) begin
                            m_state = M_DONE; m_dcnt = 0;
                        end
                    end
                end
            end
            M_PAUSED: begin
                if (sp) begin
                    m_state = M_IDLE; m_min = 0; m_sec = 0;
                end else if (st && door_closed) begin
                    m_state = M_COOK; m_presc = 0;
                end
            end
            default: begin
                if (st || sp || !door_closed) m_state = M_IDLE;
                else begin
                    m_presc++;
                    if (m_presc == TPS) begin
                        m_presc = 0;
                        m_dcnt++;
                        if (m_dcnt == DSS) m_state = M_IDLE;
                    end
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("ones",  seconds_ones_out, seg_tab[m_sec % 10]);
        chk("tens",  seconds_tens_out, seg_tab[m_sec / 10]);
        chk("mins",  minutes_out,      seg_tab[m_min]);
        chk("power", power_level,      m_power);
        chk("done",  done,             m_state == M_DONE);
        chk("mag",   mag_on,           (m_state == M_COOK) && door_closed && (m_duty < m_power));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press_start();
        startn = 1'b0; step(); startn = 1'b1; step();
    endtask

    task automatic press_stop();
        stopn = 1'b0; step(); stopn = 1'b1; step();
    endtask

    task automatic press_power();
        powern = 1'b0; step(); powern = 1'b1; step();
    endtask

    task automatic key(input int k);
        keypad = 10'd1 << k; step(); keypad = 10'd0; step();
    endtask

    initial begin
        int on_cnt;
        int w;
        clearn = 1'b0; keypad = '0; startn = 1'b1; stopn = 1'b1; powern = 1'b1; door_closed = 1'b1;
        step();
        chk("rst_ones", seconds_ones_out, 7'h3F);
        chk("rst_mins", minutes_out, 7'h3F);
        chk("rst_power", power_level, 4'd10);
        chk("rst_mag", mag_on, 1'b0);
        chk("rst_done", done, 1'b0);
        clearn = 1'b1;
        step();

        // Entry 3:59 and a refused start with the door open.
        key(3); key(5); key(9);
        chk("entry_min", minutes_out, 7'h4F);
        chk("entry_tens", seconds_tens_out, 7'h6D);
        chk("entry_ones", seconds_ones_out, 7'h6F);
        door_closed = 1'b0;
        press_start();
        chk("open_start_mag", mag_on, 1'b0);
        chk("open_start_ones", seconds_ones_out, 7'h6F);

        // Cook: first decrement after TPS cycles, borrow into minutes after 60 ticks.
        door_closed = 1'b1;
        startn = 1'b0; step();
        chk("start_mag", mag_on, 1'b1);
        startn = 1'b1; step();
        run(2);
        chk("pre_tick_ones", seconds_ones_out, 7'h6F);
        run(1);
        chk("tick_ones", seconds_ones_out, 7'h7F);
        run(59 * TPS);
        chk("borrow_min", minutes_out, 7'h5B);
        chk("borrow_tens", seconds_tens_out, 7'h6D);
        chk("borrow_ones", seconds_ones_out, 7'h6F);
        press_stop();
        chk("pause_mag", mag_on, 1'b0);
        press_stop();
        chk("clear_ones", seconds_ones_out, 7'h3F);

        // Power 3 duty window, then full power.
        press_power(); key(3);
        chk("power3", power_level, 4'd3);
        key(2); key(0);
        startn = 1'b0; step(); on_cnt = int'(mag_on); startn = 1'b1;
        for (int i = 0; i < 39; i++) begin step(); on_cnt += int'(mag_on); end
        chk("duty3_on", on_cnt, 12);
        press_stop(); press_stop();
        press_power(); key(0);
        chk("power_full", power_level, 4'd10);
        key(2); key(0);
        startn = 1'b0; step(); on_cnt = int'(mag_on); startn = 1'b1;
        for (int i = 0; i < 39; i++) begin step(); on_cnt += int'(mag_on); end
        chk("duty10_on", on_cnt, 40);
        press_stop(); press_stop();

        // Door opening mid-cook, resume, stop from pause.
        key(1); key(5);
        press_start(); run(6);
        chk("cook_mag", mag_on, 1'b1);
        door_closed = 1'b0;
        #1;
        chk("door_comb_mag", mag_on, 1'b0);
        step();
        run(8);
        chk("frozen_ones", seconds_ones_out, 7'h66);
        chk("frozen_tens", seconds_tens_out, 7'h06);
        door_closed = 1'b1;
        press_start();
        chk("resume_mag", mag_on, 1'b1);
        press_stop(); press_stop();
        chk("stop_pause_tens", seconds_tens_out, 7'h3F);
        chk("stop_pause_ones", seconds_ones_out, 7'h3F);

        // Expiry and alert length, then an aborted alert.
        key(2); press_start();
        w = 0;
        while (!done && w < 50) begin step(); w++; end
        chk("done_rise", done, 1'b1);
        on_cnt = 0;
        while (done && on_cnt < 50) begin on_cnt++; step(); end
        chk("done_len", on_cnt, DSS * TPS);
        chk("after_done_mag", mag_on, 1'b0);
        key(2); press_start();
        w = 0;
        while (!done && w < 50) begin step(); w++; end
        chk("done_rise2", done, 1'b1);
        startn = 1'b0; step();
        chk("done_abort", done, 1'b0);
        startn = 1'b1; step();

        // Reset mid-cook at 1:30 with reduced power.
        press_power(); key(5);
        key(1); key(3); key(0);
        press_start(); run(5);
        clearn = 1'b0; step();
        chk("midrst_mag", mag_on, 1'b0);
        chk("midrst_min", minutes_out, 7'h3F);
        chk("midrst_tens", seconds_tens_out, 7'h3F);
        chk("midrst_ones", seconds_ones_out, 7'h3F);
        chk("midrst_power", power_level, 4'd10);
        clearn = 1'b1; step();

        // Simultaneous start and stop while cooking pauses.
        key(5); press_start(); run(3);
        startn = 1'b0; stopn = 1'b0; step();
        startn = 1'b1; stopn = 1'b1; step();
        chk("both_mag", mag_on, 1'b0);
        chk("both_ones", seconds_ones_out, 7'h66);
        press_start();
        chk("both_resume_mag", mag_on, 1'b1);
        press_stop(); press_stop();

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    if ($urandom_range(0, 3) == 0) keypad = 10'($urandom_range(1, 1023));
                    else keypad = 10'd1 << $urandom_range(0, 9);
                    run($urandom_range(1, 3));
                    keypad = '0; step();
                end
                3: press_start();
                4: if ($urandom_range(0, 2) == 0) press_stop(); else step();
                5: press_power();
                6: begin
                    if (!door_closed || $urandom_range(0, 3) == 0) door_closed = ~door_closed;
                    step();
                end
                7: run($urandom_range(1, 12));
                8: begin
                    startn = 1'($urandom); stopn = 1'($urandom); powern = 1'($urandom);
                    step();
                    startn = 1'b1; stopn = 1'b1; powern = 1'b1;
                    step();
                end
                default: begin
                    if ($urandom_range(0, 15) == 0) begin
                        clearn = 1'b0; step(); clearn = 1'b1;
                    end
                    step();
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Parametrised next-generation microwave controller: accepts BCD cook time from a one-hot keypad, counts it down in real seconds, and drives the magnetron with a selectable power-level duty cycle, door interlock, pause/resume and an end-of-cook alert. It sits between the debounced front-panel inputs and the seven-segment display and magnetron driver. Minutes width, tick rate, duty window and alert length are parameters.

## Interface
- TICKS_PER_SEC, 100000000, clk cycles per one-second tick (>=2)
- MIN_DIGITS, 1, number of BCD minute digits (1..3)
- DUTY_WINDOW_S, 10, power duty window length in seconds (2..15)
- DONE_SECS, 3, seconds `done` stays high after expiry (>=1)
- clk  in  1  system clock, all logic on rising edge
- clearn  in  1  reset: one clock; reset is synchronous and active-low
- keypad  in  10  one-hot digit keys, bit i = digit i, active-high
- startn  in  1  start button, active-low
- stopn  in  1  stop/clear button, active-low
- powern  in  1  power-set button, active-low
- door_closed  in  1  1 = door closed
- seconds_ones_out  out  7  seven-seg, bit0=a..bit6=g, active-high
- seconds_tens_out  out  7  seven-seg, same encoding
- minutes_out  out  7*MIN_DIGITS  seven-seg, digit 0 (least significant) in [6:0]
- power_level  out  4  current power setting, 1..DUTY_WINDOW_S
- mag_on  out  1  magnetron enable
- done  out  1  end-of-cook alert

## Operation
- Inputs synchronous to clk, debounced upstream. Button press = registered previous 1, current 0 (one event per press). Key press = keypad goes from 0 to exactly one bit set; multi-hot or held keys produce no event.
- States: IDLE, PWR_SET, COOK, PAUSED, DONE.
- IDLE: key event shifts digit in: minutes[top] dropped, minutes <- shift with tens, tens <- ones, ones <- key. stopn press clears all digits to 0 and power to DUTY_WINDOW_S. powern press -> PWR_SET. startn press with door_closed=1 and time != 0 -> COOK, prescaler and duty counter cleared. startn with door open or time 0: ignored.
- PWR_SET: key event d sets power = (d==0 or d>=DUTY_WINDOW_S) ? DUTY_WINDOW_S : d, -> IDLE. stopn press -> IDLE, power unchanged. Other inputs ignored.
- COOK: prescaler counts 0..TICKS_PER_SEC-1; wrap = second tick. On tick: decrement BCD with borrow (ones 0->9 borrowing tens; tens 0->5 borrowing minutes; minutes BCD borrow chain); duty counter increments modulo DUTY_WINDOW_S. Decrement reaching all-zero -> DONE. Door opens or stopn press -> PAUSED (time held). Keypad, powern ignored.
- PAUSED: startn press with door_closed=1 -> COOK, prescaler cleared, duty counter preserved. stopn press -> IDLE, digits cleared.
- DONE: done=1; counts DONE_SECS ticks then -> IDLE. Any startn/stopn press or door opening -> IDLE immediately.
- mag_on = (state==COOK) & door_closed & (duty_cnt < power_level); door_closed gating is combinational (safety path); rest registered.
- Entered tens digit may exceed 5 (e.g. 0:99); counts down unmodified; borrows always reload tens with 5.
- Seven-seg: standard 0-9 patterns; no blanking.
- Priority per cycle: clearn > door open > stopn > startn > keypad/powern. Simultaneous startn and stopn: stop wins.

## Timing
- Reset (clearn=0 at clock edge): state IDLE, digits 0, power_level=DUTY_WINDOW_S, prescaler/duty/done counters 0, mag_on=0, done=0, all digit outputs = pattern "0" (7'h3F). Reset mid-cook drops mag_on on that edge.
- Press/key event at cycle n -> state/digits updated at edge n, visible cycle n+1.
- First decrement TICKS_PER_SEC cycles after COOK entry; mag_on high from cycle after entry when power>0 and door closed.
- Door opens at cycle n: mag_on low same cycle (combinational), state PAUSED from n+1.
- COOK->DONE on edge of final tick; done high next cycle for exactly DONE_SECS*TICKS_PER_SEC cycles unless aborted.

## Test plan
- TICKS_PER_SEC=4: press keys 3,5,9 in IDLE -> display 3:59; startn with door open -> stays IDLE, mag_on=0.
- Close door, startn -> mag_on=1 next cycle; after 4 cycles display 3:58; after 60 ticks 2:59 (borrow check).
- Power: powern then key 3, time 0:20, start -> mag_on high 3 ticks, low 7 ticks, repeating; key 0 -> power_level=10, always on.
- Open door mid-cook -> mag_on 0 same cycle, digits frozen; close, startn -> resumes; stopn in PAUSED -> IDLE, 0:00.
- Time 0:02 to expiry -> DONE, done=1 for 12 cycles then IDLE; repeat with startn during DONE -> IDLE immediately.
- clearn=0 mid-cook at 1:30 -> next cycle mag_on=0, display 0:00, power_level=10; simultaneous startn+stopn in COOK -> PAUSED.
